quadra_seq: RTL and testbench

- Sequencer for the piecewise-quadratic approximation datapath.
- Accepts an operand x over a valid/ready handshake and splits it into a segment index x1 (upper bits) and an offset x2 (lower bits).
- Drives x1 to the coefficient LUT and captures a, b, c. Evaluates y = (a*x2 + b)*x2 + c in Horner form using one shared multiplier over successive states.
- Presents y on a valid/ready output held stable under backpressure. Sits between the operand source and the result consumer; the LUT is external and purely combinational.

---
 rtl/quadra_seq.sv | 148 ++++++++++++++
 tb/tb_quadra_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/quadra_seq.sv
// quadra_seq: sequencer for the piecewise-quadratic approximation datapath.
// It accepts an operand x and splits it into a segment index x1 (upper bits),
// which addresses the external coefficient LUT, and an offset x2 (lower bits).
// It evaluates y = (a*x2 + b)*x2 + c in Horner form on one shared multiplier
// and then holds y until the consumer accepts it.
//
// Optional build macro: QUADRA_SEQ_ROUND_EN. When it is defined, each scaling
// shift rounds to nearest, with ties going toward +inf. When it is not
// defined, each shift floors.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   operand handshake; in_x = {x1, x2}
//   lut_x1              LUT address, registered, stable for the whole op
//   lut_a/b/c           signed LUT coefficients, sampled in FETCH only
//   out_valid/out_ready result handshake; out_y is signed Q3.29
//   busy                high whenever the sequencer is not idle
//   done_cnt            count of accepted results (wraps)
module quadra_seq #(
  parameter int X1_W   = 7,
  parameter int X2_W   = 17,
  parameter int COEF_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [X1_W+X2_W-1:0] in_x,
  output logic [X1_W-1:0]      lut_x1,
  input  logic [COEF_W-1:0]    lut_a,
  input  logic [COEF_W-1:0]    lut_b,
  input  logic [COEF_W-1:0]    lut_c,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [COEF_W-1:0]    out_y,
  output logic                 busy,
  output logic [CNT_W-1:0]     done_cnt
);

  localparam int PROD_W = COEF_W + X2_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    MUL1,
    MUL2,
    DONE
  } state_t;

  state_t state, state_next;

  logic [X1_W-1:0]          x1_r;
  logic [X2_W-1:0]          x2_r;
  logic [COEF_W-1:0]        a_r, b_r, c_r, acc_r, y_r;
  logic                     out_valid_r;
  logic [CNT_W-1:0]         cnt_r;

  logic signed [COEF_W-1:0] mul_op;
  logic signed [PROD_W-1:0] prod, prod_adj;
  logic [COEF_W-1:0]        mul_res;
  logic                     unused_prod_bits;

  // The multiplier is shared: MUL1 multiplies a by x2, MUL2 multiplies acc by x2.
  always_comb begin
    mul_op = (state == MUL2) ? $signed(acc_r) : $signed(a_r);
    prod   = PROD_W'(mul_op) * PROD_W'($signed({1'b0, x2_r}));
  end

`ifdef QUADRA_SEQ_ROUND_EN
  localparam logic [PROD_W-1:0] RND_HALF = PROD_W'(1) << (X2_W - 1);
  always_comb prod_adj = prod + $signed(RND_HALF);
`else
  always_comb prod_adj = prod;
`endif

  // Taking a bit window is the same as an arithmetic shift right by X2_W
  // followed by truncation to COEF_W bits.
  always_comb begin
    mul_res          = prod_adj[X2_W +: COEF_W];
    unused_prod_bits = ^{prod_adj[PROD_W-1], prod_adj[X2_W-1:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = FETCH;
      FETCH:                  state_next = MUL1;
      MUL1:                   state_next = MUL2;
      MUL2:                   state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x1_r        <= '0;
      x2_r        <= '0;
      a_r         <= '0;
      b_r         <= '0;
      c_r         <= '0;
      acc_r       <= '0;
      y_r         <= '0;
      out_valid_r <= 1'b0;
      cnt_r       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x1_r <= in_x[X1_W+X2_W-1:X2_W];
            x2_r <= in_x[X2_W-1:0];
          end
        end
        FETCH: begin
          a_r <= lut_a;
          b_r <= lut_b;
          c_r <= lut_c;
        end
        MUL1: acc_r <= mul_res + b_r;
        MUL2: begin
          y_r         <= mul_res + c_r;
          out_valid_r <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            cnt_r       <= cnt_r + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign lut_x1    = x1_r;
  assign out_valid = out_valid_r;
  assign out_y     = y_r;
  assign done_cnt  = cnt_r;

endmodule

// File: tb/tb_quadra_seq.sv
// tb_quadra_seq: directed bench for quadra_seq with a scoreboard model.
// The LUT is modelled as random tables indexed by lut_x1. Some table entries
// are overwritten with fixed values for the directed cases. The LUT drives x
// whenever coefficients must not be sampled. The counter is instantiated
// narrow so that the wrap case is reached quickly.
module tb_quadra_seq;

  localparam int X1_W   = 7;
  localparam int X2_W   = 17;
  localparam int COEF_W = 32;
  localparam int CNT_W  = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [X1_W+X2_W-1:0] in_x;
  logic [X1_W-1:0]      lut_x1;
  logic [COEF_W-1:0]    lut_a, lut_b, lut_c;
  logic                 out_valid;
  logic                 out_ready;
  logic [COEF_W-1:0]    out_y;
  logic                 busy;
  logic [CNT_W-1:0]     done_cnt;

  logic [COEF_W-1:0] ta [128];
  logic [COEF_W-1:0] tb [128];
  logic [COEF_W-1:0] tc [128];

  logic [COEF_W-1:0] sb [$];
  int unsigned       total = 0;
  int unsigned       bad   = 0;
  logic [CNT_W-1:0]  exp_cnt;
  logic [COEF_W-1:0] hold_y;

  always #5 clk = ~clk;

  assign lut_a = (in_ready || out_valid) ? 'x : ta[lut_x1];
  assign lut_b = (in_ready || out_valid) ? 'x : tb[lut_x1];
  assign lut_c = (in_ready || out_valid) ? 'x : tc[lut_x1];

  quadra_seq #(.X1_W(X1_W), .X2_W(X2_W), .COEF_W(COEF_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .lut_x1    (lut_x1),
    .lut_a     (lut_a),
    .lut_b     (lut_b),
    .lut_c     (lut_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .busy      (busy),
    .done_cnt  (done_cnt)
  );

  function automatic logic [31:0] mstep(input logic [31:0] m, input logic [16:0] x2,
                                        input logic [31:0] add);
    longint p;
    p = longint'($signed(m)) * longint'({47'b0, x2});
`ifdef QUADRA_SEQ_ROUND_EN
    p = p + 64'sd65536;
`endif
    p = p >>> 17;
    return p[31:0] + add;
  endfunction

  function automatic logic [31:0] model(input logic [23:0] x);
    logic [6:0]  x1;
    logic [16:0] x2;
    x1 = x[23:17];
    x2 = x[16:0];
    return mstep(mstep(ta[x1], x2, tb[x1]), x2, tc[x1]);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1. Returns once the accepting edge has passed.
  task automatic send(input logic [23:0] x);
    int unsigned n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) chk("send_timeout", 64'(in_ready), 64'(1));
    in_valid = 1'b1;
    in_x     = x;
    sb.push_back(model(x));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Called right after the accepting edge. Checks the latency and the result,
  // and the handoff back to idle when out_ready is high.
  task automatic wait_out(input string tag);
    int unsigned      k;
    logic [31:0]      e;
    k = 0;
    while (k < 20) begin
      @(posedge clk); #1;
      k++;
      if (out_valid) break;
    end
    chk({tag, "_latency"}, 64'(k), 64'(3));
    e = (sb.size() > 0) ? sb.pop_front() : 'x;
    chk({tag, "_y"}, 64'(out_y), 64'(e));
    if (out_ready) begin
      @(posedge clk); #1;
      exp_cnt = exp_cnt + 1'b1;
      chk({tag, "_release_valid"}, 64'(out_valid), 64'(0));
      chk({tag, "_release_ready"}, 64'(in_ready), 64'(1));
      chk({tag, "_cnt"}, 64'(done_cnt), 64'(exp_cnt));
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      ta[i] = $urandom;
      tb[i] = $urandom;
      tc[i] = $urandom;
    end
    rst = 1'b1; in_valid = 1'b0; in_x = '0; out_ready = 1'b1; exp_cnt = '0;
    #1;
    chk("rst_in_ready",  64'(in_ready),  64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_y",     64'(out_y),     64'(0));
    chk("rst_busy",      64'(busy),      64'(0));
    chk("rst_done_cnt",  64'(done_cnt),  64'(0));
    chk("rst_lut_x1",    64'(lut_x1),    64'(0));
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    // Segment 0 at offset 0 evaluates to c exactly.
    tc[0] = 32'h16a09e66;
    send(24'h000000);
    chk("seg0_lut_x1", 64'(lut_x1), 64'(0));
    wait_out("seg0");
    chk("seg0_const", 64'(out_y), 64'(32'h16a09e66));
    chk("seg0_cnt1",  64'(done_cnt), 64'(1));

    ta[5] = 32'h20000000; tb[5] = '0; tc[5] = '0;
    send({7'd5, 17'h10000});
    wait_out("half_pos");
    chk("half_pos_const", 64'(out_y), 64'(32'h08000000));

    ta[6] = 32'hE0000000; tb[6] = '0; tc[6] = '0;
    send({7'd6, 17'h10000});
    wait_out("half_neg");
    chk("half_neg_const", 64'(out_y), 64'(32'hF8000000));

    ta[7] = 32'h1; tb[7] = '0; tc[7] = '0;
    send({7'd7, 17'h1FFFF});
    wait_out("lsb_shift");
`ifdef QUADRA_SEQ_ROUND_EN
    chk("lsb_shift_const", 64'(out_y), 64'(1));
`else
    chk("lsb_shift_const", 64'(out_y), 64'(0));
`endif

    send({7'd10, 17'h0});
    wait_out("x2_zero");
    chk("x2_zero_is_c", 64'(out_y), 64'(tc[10]));

    // Backpressure, with an operand offered while busy that must be ignored.
    out_ready = 1'b0;
    send({7'd9, 17'($urandom)});
    wait_out("bp");
    hold_y   = out_y;
    in_valid = 1'b1;
    in_x     = {7'd20, 17'($urandom)};
    repeat (10) begin
      @(posedge clk); #1;
      chk("bp_valid",    64'(out_valid), 64'(1));
      chk("bp_y",        64'(out_y),     64'(hold_y));
      chk("bp_in_ready", 64'(in_ready),  64'(0));
      chk("bp_busy",     64'(busy),      64'(1));
      chk("bp_lut_x1",   64'(lut_x1),    64'(9));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 1'b1;
    chk("bp_rel_valid", 64'(out_valid), 64'(0));
    chk("bp_rel_ready", 64'(in_ready),  64'(1));
    chk("bp_rel_cnt",   64'(done_cnt),  64'(exp_cnt));
    @(posedge clk); #1;
    chk("bp_no_ghost", 64'(busy), 64'(0));

    // Reset asserted while in MUL1.
    send({7'd33, 17'($urandom)});
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid",  64'(out_valid), 64'(0));
    chk("mid_rst_ready",  64'(in_ready),  64'(1));
    chk("mid_rst_cnt",    64'(done_cnt),  64'(0));
    chk("mid_rst_lut_x1", 64'(lut_x1),    64'(0));
    chk("mid_rst_busy",   64'(busy),      64'(0));
    void'(sb.pop_front());
    exp_cnt = '0;
    @(posedge clk); #1; rst = 1'b0;
    send({7'd33, 17'($urandom)});
    wait_out("post_rst");

    // Back-to-back traffic until the narrow counter wraps to zero.
    for (int i = 0; i < 15; i++) begin
      send(24'($urandom));
      wait_out("b2b");
    end
    chk("wrap_cnt", 64'(done_cnt), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
